// File: rtl/simon_pkg.sv
// Shared defaults, FSM state encoding and word-array types for the SIMON_128192 host controller.
package simon_pkg;

    localparam int N_DEF    = 64;
    localparam int M_DEF    = 3;
    localparam int ODEP_DEF = 2;
    localparam int TMO_DEF  = 255;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KREQ = 3'd1,
        ST_DREQ = 3'd2,
        ST_WAIT = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    typedef logic [1:0][N_DEF-1:0]       block_t;
    typedef logic [M_DEF-1:0][N_DEF-1:0] key_t;

endpackage

// File: rtl/simon_host_ctrl_if.sv
// Host request/result streams plus the SIMON_128192 core handshake, bundled as one interface.
interface simon_host_ctrl_if
    import simon_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
);
    logic             key_valid;
    logic             key_ready;
    logic [M*N-1:0]   key_in;
    logic             blk_valid;
    logic             blk_ready;
    logic [2*N-1:0]   blk_in;
    logic             blk_dir;
    logic             res_valid;
    logic             res_ready;
    logic [2*N-1:0]   res_data;
    logic             err;
    logic [M*N-1:0]   KEY;
    logic [2*N-1:0]   BLOCK;
    logic             enc_dec;
    logic             newKey;
    logic             newData;
    logic             readData;
    logic             loadKey;
    logic             loadData;
    logic             doneData;
    logic [2*N-1:0]   outData;

    // master = the controller, slave = host adapter plus core
    modport master (
        input  key_valid, key_in, blk_valid, blk_in, blk_dir, res_ready,
               loadKey, loadData, doneData, outData,
        output key_ready, blk_ready, res_valid, res_data, err,
               KEY, BLOCK, enc_dec, newKey, newData, readData
    );

    modport slave (
        output key_valid, key_in, blk_valid, blk_in, blk_dir, res_ready,
               loadKey, loadData, doneData, outData,
        input  key_ready, blk_ready, res_valid, res_data, err,
               KEY, BLOCK, enc_dec, newKey, newData, readData
    );

endinterface

// File: rtl/simon_res_fifo.sv
// Result buffer: DEPTH-entry synchronous FIFO with wrap-bit pointers, async active-low reset.
module simon_res_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         nR,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d                = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/simon_host_ctrl.sv
// Host-side driver for the SIMON_128192 core: key/block request streams in, buffered results out.
// state | meaning
// IDLE  | accept a key (priority) or a block when a key is loaded and the buffer has room
// KREQ  | newKey high, waiting for loadKey
// DREQ  | newData high, waiting for loadData
// WAIT  | core computing, waiting for doneData (result captured on that cycle)
// ACK   | readData high until the core drops doneData
module simon_host_ctrl
    import simon_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int M    = M_DEF,
    parameter int ODEP = ODEP_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic               clk,
    input  logic               nR,
    simon_host_ctrl_if.master  bus
);
    localparam int TW = $clog2(TMO + 1);

    state_t         state_q, state_d;
    logic [M*N-1:0] key_q, key_d;
    logic [2*N-1:0] blk_q, blk_d;
    logic           enc_dec_q, enc_dec_d;
    logic           new_key_q, new_key_d;
    logic           new_data_q, new_data_d;
    logic           read_data_q, read_data_d;
    logic           err_q, err_d;
    logic           key_loaded_q, key_loaded_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           timeout;
    logic           key_acc, blk_acc;
    logic           fifo_push, fifo_empty, fifo_full;

    assign key_acc = (state_q == ST_IDLE) && bus.key_valid;
    assign blk_acc = (state_q == ST_IDLE) && !bus.key_valid && bus.blk_valid
                     && key_loaded_q && !fifo_full;
    assign timeout = (tmo_q == '0);

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        blk_d        = blk_q;
        enc_dec_d    = enc_dec_q;
        new_key_d    = new_key_q;
        new_data_d   = new_data_q;
        read_data_d  = read_data_q;
        err_d        = err_q;
        key_loaded_d = key_loaded_q;
        tmo_d        = tmo_q;
        fifo_push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_acc) begin
                    key_d     = bus.key_in;
                    new_key_d = 1'b1;
                    state_d   = ST_KREQ;
                end else if (blk_acc) begin
                    blk_d      = bus.blk_in;
                    enc_dec_d  = bus.blk_dir;
                    new_data_d = 1'b1;
                    state_d    = ST_DREQ;
                end
            end
            ST_KREQ: begin
                if (bus.loadKey) begin
                    new_key_d    = 1'b0;
                    key_loaded_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (timeout) begin
                    new_key_d    = 1'b0;
                    key_loaded_d = 1'b0;
                    err_d        = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_DREQ: begin
                if (bus.loadData) begin
                    new_data_d = 1'b0;
                    state_d    = ST_WAIT;
                end else if (timeout) begin
                    new_data_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.doneData) begin
                    fifo_push   = 1'b1;
                    read_data_d = 1'b1;
                    state_d     = ST_ACK;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!bus.doneData) begin
                    read_data_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (timeout) begin
                    read_data_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                new_key_d   = 1'b0;
                new_data_d  = 1'b0;
                read_data_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        // Watchdog is a down-counter reloaded on every state change; zero means TMO cycles spent.
        if (state_d != state_q) begin
            tmo_d = TW'(TMO - 1);
        end else if (state_q != ST_IDLE) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            blk_q        <= '0;
            enc_dec_q    <= 1'b0;
            new_key_q    <= 1'b0;
            new_data_q   <= 1'b0;
            read_data_q  <= 1'b0;
            err_q        <= 1'b0;
            key_loaded_q <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            blk_q        <= blk_d;
            enc_dec_q    <= enc_dec_d;
            new_key_q    <= new_key_d;
            new_data_q   <= new_data_d;
            read_data_q  <= read_data_d;
            err_q        <= err_d;
            key_loaded_q <= key_loaded_d;
            tmo_q        <= tmo_d;
        end
    end

    simon_res_fifo #(
        .W     (2 * N),
        .DEPTH (ODEP)
    ) u_res_fifo (
        .clk   (clk),
        .nR    (nR),
        .push  (fifo_push),
        .wdata (bus.outData),
        .pop   (bus.res_ready),
        .rdata (bus.res_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.res_valid = !fifo_empty;
    assign bus.key_ready = key_acc;
    assign bus.blk_ready = blk_acc;
    assign bus.err       = err_q;
    assign bus.KEY       = key_q;
    assign bus.BLOCK     = blk_q;
    assign bus.enc_dec   = enc_dec_q;
    assign bus.newKey    = new_key_q;
    assign bus.newData   = new_data_q;
    assign bus.readData  = read_data_q;

endmodule
